seg_scan_capture: RTL
=====================

Name: seg_scan_capture

Overview:
- Receiving end of the 7-segment display interface: watches a time-multiplexed scanned display bus (digit select plus segment lines) and converts each digit's pattern back to 8421 BCD.
- Uses a per-digit stability filter and assembles a full frame of digits.
- Presents the frame with a valid/ack handshake.
- Used as a loop-back checker for display drivers and to read a scanned display into logic.

Parameters:
- DIGITS, 8, number of scanned digit positions.
- STABLE_CYCLES, 4, consecutive identical samples required before a digit is committed (≥2).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- SEG  input  9  segment lines, active-high; bit0=a … bit6=g; bits 8:7 ignored.
- CAT  input  DIGITS  digit select, active-low one-hot; bit k low selects digit k.
- BCD  output  4*DIGITS  frame digits; digit k at BCD[4k+3:4k]; 4'hF means blank.
- DigitErr  output  DIGITS  bit k set if digit k's pattern was not a legal code.
- FrameValid  output  1  frame on BCD/DigitErr is available; held until accepted.
- FrameAck  input  1  consumer accepts the frame when FrameValid=1.
- Overrun  output  1  sticky; a completed frame was dropped because the previous one was not yet acked.

Behaviour:
- Reset (async, rst=1): BCD=0, DigitErr=0, FrameValid=0, Overrun=0; input registers, stability counter, committed flag, seen mask and shadow registers all cleared.
- Input stage: SEG[6:0] and CAT are registered every cycle (seg_q, cat_q); all logic works on the registered values.
- Select validity: cat_q is valid only if exactly one bit is low. If invalid (none low, or several low):
  - stability counter cleared;
  - committed flag cleared;
  - no commit that cycle.
- Stability counter:
  - When seg_q and cat_q both equal their previous-cycle values, the counter increments, saturating at STABLE_CYCLES-1.
  - Any change clears the counter and the committed flag.
- Commit: when the counter reaches STABLE_CYCLES-1 with valid select index k and committed flag clear:
  - decode seg_q into shadow digit k and shadow error k;
  - set seen[k];
  - set the committed flag, so only one commit happens per dwell.
- Latency: if SEG/CAT are steady from clock edge E (first edge that samples them), the commit happens at edge E+STABLE_CYCLES.
- Decode table (7-bit gfedcba):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9;
  - 00→F (blank), error 0;
  - any other pattern→F, error 1.
- Frame completion: the frame completes on the edge after seen becomes all-ones. At that edge:
  - seen is cleared;
  - if FrameValid=0, or FrameValid=1 with FrameAck=1 in the same cycle: shadow copied to BCD/DigitErr, FrameValid=1;
  - otherwise (FrameValid=1, no ack): frame dropped, BCD/DigitErr unchanged, Overrun set.
- Ack without a new frame: clears FrameValid and Overrun the next edge. BCD/DigitErr retain their values.
- Re-commits: a digit re-committed before frame completion overwrites its shadow entry. seen is unaffected.
- Scan order: arbitrary; any order or repetition is acceptable. A frame completes only when every position has committed at least once.
- Mid-operation reset: aborts a partial frame immediately; no frame is emitted from pre-reset samples.

Decomposition:
- Shared package seg_pkg holds:
  - segment pattern constants SEG_0..SEG_9 and SEG_BLANK (7-bit);
  - BCD_BLANK = 4'hF.
  These are the same constants used by the display encoders.
- One combinational sub-module, seg7_pattern_decode: 7-bit pattern in → 4-bit code + err out, implementing the table above.
- Counters, seen mask and handshake stay in seg_scan_capture.

Test Plan:
Bench configuration: DIGITS=4, STABLE_CYCLES=4.
1. Basic frame: scan CAT=1110,1101,1011,0111 with SEG=06,5B,4F,66, each held 6 cycles, FrameAck=0.
   → FrameValid=1 at the edge after the 4th commit; BCD=16'h4321; DigitErr=0000.
2. Glitch rejection: hold digit 0 with SEG alternating 3F/06 every 2 cycles, then steady 7F for 6 cycles.
   → only 8 committed; BCD[3:0]=8.
3. Illegal and blank patterns: digit 1 SEG=01, digit 2 SEG=00, others legal.
   → BCD[7:4]=F, DigitErr[1]=1; BCD[11:8]=F, DigitErr[2]=0.
4. Overrun: complete two frames with no FrameAck.
   → second frame dropped, BCD holds the first frame, Overrun=1.
   Then pulse FrameAck one cycle → FrameValid=0, Overrun=0 the next cycle.
5. Invalid select: CAT=1100 held 10 cycles → no commit, seen unchanged. CAT=1111 likewise → no commit.
6. Reset mid-frame: after 2 digits committed, assert rst one cycle, then scan all 4 digits.
   → FrameValid rises only after all 4 post-reset commits. Outputs read 0 while rst is high.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: segment patterns (gfedcba, active-high)
// and the BCD code used for a blank digit. Display encoders use the same set.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] BCD_BLANK = 4'hF;

  // Decoded digit: BCD code plus an illegal-pattern flag.
  typedef struct packed {
    logic [3:0] code;
    logic       err;
  } seg_decode_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to 8421 BCD decoder.
// Blank decodes to BCD_BLANK without error; unknown patterns decode to
// BCD_BLANK with err set.
module seg7_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] code,
  output logic       err
);

  seg_decode_t dec;

  // Table lookup; default covers every unlisted pattern as illegal.
  always_comb begin
    dec.code = BCD_BLANK;
    dec.err  = 1'b1;
    case (pattern)
      SEG_0:     begin dec.code = 4'd0;      dec.err = 1'b0; end
      SEG_1:     begin dec.code = 4'd1;      dec.err = 1'b0; end
      SEG_2:     begin dec.code = 4'd2;      dec.err = 1'b0; end
      SEG_3:     begin dec.code = 4'd3;      dec.err = 1'b0; end
      SEG_4:     begin dec.code = 4'd4;      dec.err = 1'b0; end
      SEG_5:     begin dec.code = 4'd5;      dec.err = 1'b0; end
      SEG_6:     begin dec.code = 4'd6;      dec.err = 1'b0; end
      SEG_7:     begin dec.code = 4'd7;      dec.err = 1'b0; end
      SEG_8:     begin dec.code = 4'd8;      dec.err = 1'b0; end
      SEG_9:     begin dec.code = 4'd9;      dec.err = 1'b0; end
      SEG_BLANK: begin dec.code = BCD_BLANK; dec.err = 1'b0; end
      default:   begin dec.code = BCD_BLANK; dec.err = 1'b1; end
    endcase
  end

  assign code = dec.code;
  assign err  = dec.err;

endmodule

// File: rtl/seg_scan_capture.sv
// Scanned 7-segment display capture: registers the SEG/CAT bus, filters each
// digit dwell for stability, decodes committed digits into a shadow frame and
// hands complete frames out with a valid/ack handshake and sticky overrun.
module seg_scan_capture
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 8,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8:0]            SEG,
  input  logic [DIGITS-1:0]     CAT,
  output logic [4*DIGITS-1:0]   BCD,
  output logic [DIGITS-1:0]     DigitErr,
  output logic                  FrameValid,
  input  logic                  FrameAck,
  output logic                  Overrun
);

  localparam int unsigned CNT_W  = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SELC_W = $clog2(DIGITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  // Input stage and previous-cycle copies
  logic [6:0]            seg_q, seg_d, seg_prev_q, seg_prev_d;
  logic [DIGITS-1:0]     cat_q, cat_d, cat_prev_q, cat_prev_d;

  // Stability filter
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  committed_q, committed_d;
  logic                  commit;

  // Frame assembly and output registers
  logic [DIGITS-1:0]     seen_q, seen_d;
  logic [4*DIGITS-1:0]   shadow_bcd_q, shadow_bcd_d;
  logic [DIGITS-1:0]     shadow_err_q, shadow_err_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [DIGITS-1:0]     err_q, err_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  // Select decode and pattern decode
  logic [SELC_W-1:0]     sel_cnt;
  logic [IDX_W-1:0]      sel_idx;
  logic                  sel_valid;
  logic                  same;
  logic [3:0]            dec_code;
  logic                  dec_err;
  logic                  unused_seg_hi;

  assign unused_seg_hi = ^SEG[8:7];

  // Next input-stage values: sample the bus, remember the previous sample.
  always_comb begin
    seg_d      = SEG[6:0];
    cat_d      = CAT;
    seg_prev_d = seg_q;
    cat_prev_d = cat_q;
  end

  // Input registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q      <= '0;
      cat_q      <= '0;
      seg_prev_q <= '0;
      cat_prev_q <= '0;
    end else begin
      seg_q      <= seg_d;
      cat_q      <= cat_d;
      seg_prev_q <= seg_prev_d;
      cat_prev_q <= cat_prev_d;
    end
  end

  // Count active-low select bits and capture the selected index.
  always_comb begin
    sel_cnt = '0;
    sel_idx = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!cat_q[i]) begin
        sel_cnt = sel_cnt + SELC_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
  end

  assign sel_valid = (sel_cnt == SELC_W'(1));
  assign same      = (seg_q == seg_prev_q) && (cat_q == cat_prev_q);

  seg7_pattern_decode u_decode (
    .pattern (seg_q),
    .code    (dec_code),
    .err     (dec_err)
  );

  // Stability counter: commit fires on the cycle the counter reaches its
  // saturation value, so a dwell steady from edge E commits at E+STABLE_CYCLES.
  always_comb begin
    cnt_d       = cnt_q;
    committed_d = committed_q;
    commit      = 1'b0;
    if (!sel_valid || !same) begin
      cnt_d       = '0;
      committed_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if ((cnt_d == CNT_MAX) && !committed_q) begin
        commit      = 1'b1;
        committed_d = 1'b1;
      end
    end
  end

  // Stability counter and committed flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      committed_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
    end
  end

  // Frame completion and handshake first, then the digit commit; the output
  // copy uses the registered shadow, and a same-cycle commit lands in the
  // fresh seen mask.
  always_comb begin
    seen_d       = seen_q;
    shadow_bcd_d = shadow_bcd_q;
    shadow_err_d = shadow_err_q;
    bcd_d        = bcd_q;
    err_d        = err_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;

    if (&seen_q) begin
      seen_d = '0;
      if (!valid_q || FrameAck) begin
        bcd_d     = shadow_bcd_q;
        err_d     = shadow_err_q;
        valid_d   = 1'b1;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && FrameAck) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    if (commit) begin
      shadow_bcd_d[4*int'(sel_idx) +: 4] = dec_code;
      shadow_err_d[sel_idx]              = dec_err;
      seen_d[sel_idx]                    = 1'b1;
    end
  end

  // Frame assembly and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q       <= '0;
      shadow_bcd_q <= '0;
      shadow_err_q <= '0;
      bcd_q        <= '0;
      err_q        <= '0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      seen_q       <= seen_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_err_q <= shadow_err_d;
      bcd_q        <= bcd_d;
      err_q        <= err_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign BCD        = bcd_q;
  assign DigitErr   = err_q;
  assign FrameValid = valid_q;
  assign Overrun    = overrun_q;

endmodule
